// File: rtl/ece453_avmm_pkg.sv
// Shared types for the ece453 Avalon-MM master.
// FSM encoding, command entry layout, error data.
package ece453_avmm_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RDWAIT,
    RESP
  } state_t;

  // Entry layout, MSB first:
  // {write, byteenable, writedata, address}
  localparam int BE_W   = 4;
  localparam int DATA_W = 32;

  localparam logic [DATA_W-1:0] ERR_DATA = 32'h0;

endpackage

// File: rtl/ece453_cmd_fifo.sv
// Show-ahead command FIFO, registered storage.
// Full blocks push even when a pop is concurrent.
module ece453_cmd_fifo #(
  parameter int WIDTH = 41,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)
        count <= count + 1'b1;
      else if (do_pop && !do_push)
        count <= count - 1'b1;
    end
  end

  // Entry storage; contents are don't-care when empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/ece453_avmm_master.sv
// Avalon-MM master: queued commands become single
// transfers with waitrequest, latency and timeout.
module ece453_avmm_master
  import ece453_avmm_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int FIFO_DEPTH   = 4,
  parameter int READ_LATENCY = 0,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_address,
  input  logic [31:0]       cmd_writedata,
  input  logic [3:0]        cmd_byteenable,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_readdata,
  output logic              rsp_write,
  output logic              rsp_error,
  output logic [ADDR_W-1:0] master_address,
  output logic              master_read,
  output logic              master_write,
  output logic [31:0]       master_writedata,
  output logic [3:0]        master_byteenable,
  input  logic [31:0]       master_readdata,
  input  logic              master_waitrequest,
  output logic              busy
);

  localparam int ENTRY_W = 1 + BE_W + DATA_W + ADDR_W;
  localparam int WD_LSB  = ADDR_W;
  localparam int BE_LSB  = ADDR_W + DATA_W;
  localparam int TW      = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);
  localparam logic [1:0] LAT = 2'(READ_LATENCY);

  state_t              state, state_n;
  logic [ENTRY_W-1:0]  din, dout;
  logic                full, empty, push, pop;
  logic [TW-1:0]       tcnt, tcnt_n;
  logic [1:0]          lcnt, lcnt_n;
  logic [ADDR_W-1:0]   addr_n;
  logic                rd_n, wr_n;
  logic [31:0]         wdata_n;
  logic [3:0]          be_n;
  logic                rv_n, rwr_n, rerr_n;
  logic [31:0]         rdata_n;

  assign cmd_ready = !full && !reset;
  assign push      = cmd_valid && cmd_ready;
  assign din = {cmd_write, cmd_byteenable,
                cmd_writedata, cmd_address};
  assign busy = !empty || (state != IDLE);

  ece453_cmd_fifo #(
    .WIDTH(ENTRY_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (clk),
    .reset(reset),
    .push (push),
    .pop  (pop),
    .din  (din),
    .dout (dout),
    .full (full),
    .empty(empty)
  );

  // Next state and next registered bus/response values.
  always_comb begin
    state_n = state;
    tcnt_n  = tcnt;
    lcnt_n  = lcnt;
    pop     = 1'b0;
    addr_n  = master_address;
    rd_n    = master_read;
    wr_n    = master_write;
    wdata_n = master_writedata;
    be_n    = master_byteenable;
    rv_n    = rsp_valid;
    rdata_n = rsp_readdata;
    rwr_n   = rsp_write;
    rerr_n  = rsp_error;
    unique case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          addr_n  = dout[ADDR_W-1:0];
          wdata_n = dout[WD_LSB +: DATA_W];
          be_n    = dout[BE_LSB +: BE_W];
          wr_n    = dout[ENTRY_W-1];
          rd_n    = !dout[ENTRY_W-1];
          tcnt_n  = '0;
          state_n = ISSUE;
        end
      end
      ISSUE: begin
        if (!master_waitrequest) begin
          rd_n = 1'b0;
          wr_n = 1'b0;
          if (master_write) begin
            rv_n    = 1'b1;
            rwr_n   = 1'b1;
            rerr_n  = 1'b0;
            rdata_n = ERR_DATA;
            state_n = RESP;
          end else if (READ_LATENCY == 0) begin
            rv_n    = 1'b1;
            rwr_n   = 1'b0;
            rerr_n  = 1'b0;
            rdata_n = master_readdata;
            state_n = RESP;
          end else begin
            lcnt_n  = 2'd1;
            state_n = RDWAIT;
          end
        end else begin
          if (tcnt != TMAX) tcnt_n = tcnt + 1'b1;
          if (tcnt_n == TMAX) begin
            rd_n    = 1'b0;
            wr_n    = 1'b0;
            rv_n    = 1'b1;
            rwr_n   = master_write;
            rerr_n  = 1'b1;
            rdata_n = ERR_DATA;
            state_n = RESP;
          end
        end
      end
      RDWAIT: begin
        if (lcnt == LAT) begin
          rv_n    = 1'b1;
          rwr_n   = 1'b0;
          rerr_n  = 1'b0;
          rdata_n = master_readdata;
          state_n = RESP;
        end else begin
          lcnt_n = lcnt + 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          rv_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // State, counters and all registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      tcnt              <= '0;
      lcnt              <= '0;
      master_address    <= '0;
      master_read       <= 1'b0;
      master_write      <= 1'b0;
      master_writedata  <= '0;
      master_byteenable <= '0;
      rsp_valid         <= 1'b0;
      rsp_readdata      <= '0;
      rsp_write         <= 1'b0;
      rsp_error         <= 1'b0;
    end else begin
      state             <= state_n;
      tcnt              <= tcnt_n;
      lcnt              <= lcnt_n;
      master_address    <= addr_n;
      master_read       <= rd_n;
      master_write      <= wr_n;
      master_writedata  <= wdata_n;
      master_byteenable <= be_n;
      rsp_valid         <= rv_n;
      rsp_readdata      <= rdata_n;
      rsp_write         <= rwr_n;
      rsp_error         <= rerr_n;
    end
  end

endmodule

// File: tb/tb_ece453_avmm_master.sv
// Bench for ece453_avmm_master: two instances
// (read latency 0 and 2) against a queue model.
module tb_ece453_avmm_master;

  localparam int TO = 8;

  typedef struct {
    bit          w;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  typedef struct {
    bit          w;
    logic [4:0]  a;
    logic [31:0] d;
    logic [3:0]  be;
    int          stall;
  } cmd_t;

  logic clk = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   done [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] seed(input int i);
    if (i == 0) return 32'hECE45318;
    return (32'h9E3779B9 * i) ^ 32'h5A5A0000;
  endfunction

  task automatic check(input int inst, input string name,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL [%0d] %s: got %h expected %h",
               inst, name, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g
    localparam int RL = 2 * gi;

    logic        reset;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [4:0]  cmd_address;
    logic [31:0] cmd_writedata;
    logic [3:0]  cmd_byteenable;
    logic        rsp_valid, rsp_write, rsp_error;
    logic        rsp_ready = 1'b1;
    logic [31:0] rsp_readdata;
    logic [4:0]  master_address;
    logic        master_read, master_write;
    logic [31:0] master_writedata, master_readdata;
    logic [3:0]  master_byteenable;
    logic        master_waitrequest = 1'b0;
    logic        busy;

    ece453_avmm_master #(
      .ADDR_W(5),
      .FIFO_DEPTH(4),
      .READ_LATENCY(RL),
      .TIMEOUT(TO)
    ) dut (
      .clk               (clk),
      .reset             (reset),
      .cmd_valid         (cmd_valid),
      .cmd_ready         (cmd_ready),
      .cmd_write         (cmd_write),
      .cmd_address       (cmd_address),
      .cmd_writedata     (cmd_writedata),
      .cmd_byteenable    (cmd_byteenable),
      .rsp_valid         (rsp_valid),
      .rsp_ready         (rsp_ready),
      .rsp_readdata      (rsp_readdata),
      .rsp_write         (rsp_write),
      .rsp_error         (rsp_error),
      .master_address    (master_address),
      .master_read       (master_read),
      .master_write      (master_write),
      .master_writedata  (master_writedata),
      .master_byteenable (master_byteenable),
      .master_readdata   (master_readdata),
      .master_waitrequest(master_waitrequest),
      .busy              (busy)
    );

    rsp_t        rq [$];
    cmd_t        bq [$];
    logic [31:0] mmem [32];
    logic [31:0] smem [32];
    logic [31:0] rd_data;
    logic [31:0] junk = 32'hDEADBEEF;
    int          rd_cnt;
    int          rr_mode = 0;

    // Slave storage and read-latency pipeline.
    always @(posedge clk) begin
      if (reset) begin
        rd_cnt <= 0;
        for (int i = 0; i < 32; i++) smem[i] <= seed(i);
      end else begin
        if (rd_cnt != 0) rd_cnt <= rd_cnt - 1;
        if (master_read && !master_waitrequest) begin
          rd_data <= smem[master_address];
          rd_cnt  <= RL;
        end
        if (master_write && !master_waitrequest)
          for (int b = 0; b < 4; b++)
            if (master_byteenable[b])
              smem[master_address][8*b +: 8] <=
                master_writedata[8*b +: 8];
      end
    end

    // Readdata is only meaningful in its valid cycle.
    always_comb begin
      master_readdata = junk;
      if (RL == 0) begin
        if (master_read && !master_waitrequest)
          master_readdata = smem[master_address];
      end else if (rd_cnt == 1) begin
        master_readdata = rd_data;
      end
    end

    bit          req_d = 1'b0;
    bit          prev_wait = 1'b0;
    int          left = 0;
    int          dur = 0;
    int          cur_stall = 0;
    logic [42:0] snap;

    // Bus monitor and waitrequest driver.
    always @(negedge clk) begin
      bit   req;
      cmd_t c;
      junk = $urandom;
      req  = master_read | master_write;
      if (reset) begin
        req_d = 1'b0;
        prev_wait = 1'b0;
        master_waitrequest = 1'b0;
        dur = 0;
      end else begin
        check(gi, "rd_wr_excl",
              64'(master_read & master_write), 64'd0);
        if (req && !req_d) begin
          check(gi, "bus_expected", 64'(bq.size() != 0), 64'd1);
          if (bq.size() != 0) begin
            c = bq.pop_front();
            check(gi, "bus_addr", 64'(master_address), 64'(c.a));
            check(gi, "bus_write", 64'(master_write), 64'(c.w));
            if (c.w) begin
              check(gi, "bus_wdata",
                    64'(master_writedata), 64'(c.d));
              check(gi, "bus_be",
                    64'(master_byteenable), 64'(c.be));
            end
            cur_stall = c.stall;
            left = c.stall;
          end
          dur = 0;
        end
        if (req_d && prev_wait && req)
          check(gi, "bus_hold",
                64'({master_address, master_read, master_write,
                     master_writedata, master_byteenable}),
                64'(snap));
        if (!req && req_d)
          check(gi, "req_cycles", 64'(dur),
                64'(cur_stall >= TO ? TO : cur_stall + 1));
        if (req) dur++;
        master_waitrequest = req && (left > 0);
        if (master_waitrequest) left--;
        snap = {master_address, master_read, master_write,
                master_writedata, master_byteenable};
        prev_wait = master_waitrequest;
        req_d = req;
      end
    end

    bit          pv = 1'b0;
    bit          prr = 1'b0;
    logic [33:0] rsnap;

    // Response monitor: pops the scoreboard on handshake.
    always @(negedge clk) begin
      rsp_t e;
      if (reset) begin
        pv = 1'b0;
      end else begin
        if (pv && !prr)
          check(gi, "rsp_hold",
                64'({rsp_valid, rsp_write, rsp_error,
                     rsp_readdata}),
                64'({1'b1, rsnap}));
        rsp_ready = (rr_mode == 0) ? 1'b1 :
                    (rr_mode == 1) ? 1'b0 : 1'($urandom);
        if (rsp_valid && rsp_ready) begin
          check(gi, "rsp_expected", 64'(rq.size() != 0), 64'd1);
          if (rq.size() != 0) begin
            e = rq.pop_front();
            check(gi, "rsp_write", 64'(rsp_write), 64'(e.w));
            check(gi, "rsp_error", 64'(rsp_error), 64'(e.err));
            check(gi, "rsp_readdata",
                  64'(rsp_readdata), 64'(e.data));
          end
        end
        pv = rsp_valid;
        prr = rsp_ready;
        rsnap = {rsp_write, rsp_error, rsp_readdata};
      end
    end

    task automatic init_model();
      for (int i = 0; i < 32; i++) mmem[i] = seed(i);
    endtask

    task automatic push(input bit w, input int a,
                        input logic [31:0] d,
                        input logic [3:0] be,
                        input int stall);
      int   n = 0;
      bit   err;
      rsp_t r;
      cmd_t c;
      cmd_valid      = 1'b1;
      cmd_write      = w;
      cmd_address    = 5'(a);
      cmd_writedata  = d;
      cmd_byteenable = be;
      while (!cmd_ready && n < 200) begin
        @(negedge clk);
        n++;
      end
      check(gi, "cmd_ready_wait", 64'(n < 200), 64'd1);
      if (n < 200) begin
        err = (stall >= TO);
        c.w = w; c.a = 5'(a); c.d = d;
        c.be = be; c.stall = stall;
        bq.push_back(c);
        if (w && !err)
          for (int b = 0; b < 4; b++)
            if (be[b]) mmem[a][8*b +: 8] = d[8*b +: 8];
        r.w = w;
        r.err = err;
        r.data = (w || err) ? 32'h0 : mmem[a];
        rq.push_back(r);
        @(negedge clk);
      end
      cmd_valid = 1'b0;
    endtask

    task automatic drain();
      int n = 0;
      while ((rq.size() != 0 || busy || rsp_valid) && n < 2000) begin
        @(negedge clk);
        n++;
      end
      check(gi, "drain", 64'(n < 2000), 64'd1);
    endtask

    function automatic int rnd_stall();
      int r = $urandom_range(0, 19);
      if (r < 14) return $urandom_range(0, 2);
      if (r < 17) return 7;
      if (r < 19) return 8;
      return 12;
    endfunction

    // Directed scenarios, then randomized traffic.
    initial begin
      reset = 1'b1;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_address = '0;
      cmd_writedata = '0;
      cmd_byteenable = '0;
      init_model();
      repeat (2) @(negedge clk);
      check(gi, "reset_outputs",
            64'({cmd_ready, rsp_valid, master_read,
                 master_write, busy, master_address,
                 rsp_readdata}), 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check(gi, "ready_after_reset", 64'(cmd_ready), 64'd1);

      push(1'b1, 1, 32'h3, 4'hF, 0);
      check(gi, "wr_lat_c1", 64'(master_write), 64'd0);
      @(negedge clk);
      check(gi, "wr_lat_c2",
            64'({master_write, master_address,
                 master_writedata}),
            64'({1'b1, 5'd1, 32'h3}));
      @(negedge clk);
      check(gi, "wr_one_cycle", 64'(master_write), 64'd0);
      drain();

      push(1'b0, 0, 32'h0, 4'hF, 0);
      drain();
      push(1'b0, 2, 32'h0, 4'hF, 5);
      drain();

      push(1'b0, 3, 32'h0, 4'hF, 8);
      push(1'b1, 4, 32'hA5A5_1234, 4'h5, 0);
      push(1'b0, 4, 32'h0, 4'hF, 2);
      push(1'b1, 5, 32'h1111_2222, 4'hF, 12);
      push(1'b0, 5, 32'h0, 4'hF, 7);
      drain();

      rr_mode = 1;
      push(1'b1, 7, 32'hCAFE_F00D, 4'hF, 0);
      push(1'b0, 7, 32'h0, 4'hF, 0);
      push(1'b0, 8, 32'h0, 4'hF, 0);
      push(1'b1, 9, 32'h0BAD_0BAD, 4'hC, 0);
      push(1'b0, 9, 32'h0, 4'hF, 0);
      check(gi, "full_ready_low", 64'(cmd_ready), 64'd0);
      repeat (3) @(negedge clk);
      check(gi, "full_busy",
            64'({busy, cmd_ready}), 64'({1'b1, 1'b0}));
      rr_mode = 2;
      drain();

      for (int i = 0; i < 60; i++) begin
        if ($urandom_range(0, 7) == 0)
          rr_mode = ($urandom_range(0, 1) == 0) ? 0 : 2;
        push(1'($urandom), $urandom_range(0, 31), $urandom,
             4'($urandom), rnd_stall());
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      rr_mode = 0;
      drain();

      push(1'b0, 10, 32'h0, 4'hF, 30);
      push(1'b0, 11, 32'h0, 4'hF, 0);
      push(1'b0, 12, 32'h0, 4'hF, 0);
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      check(gi, "reset_mid_outputs",
            64'({cmd_ready, rsp_valid, master_read,
                 master_write, busy, master_address,
                 rsp_readdata, rsp_write, rsp_error}),
            64'd0);
      rq.delete();
      bq.delete();
      init_model();
      repeat (2) @(negedge clk);
      reset = 1'b0;
      repeat (30) @(negedge clk);
      check(gi, "post_reset_idle",
            64'({busy, master_read, rsp_valid}), 64'd0);
      done[gi] = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(done[0] && done[1]) && n < 60000) begin
      @(negedge clk);
      n++;
    end
    check(9, "all_done", 64'(done[0] && done[1]), 64'd1);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
